// File: rtl/serializador_dac.sv
// serializador_dac: converts one signed fixed-point filter sample per request
// into a 12-bit offset-binary DAC code. It shifts the code out as a 16-bit
// SPI-style frame (4 mode bits, then 12 data bits, MSB first) to a
// DAC121S101-class converter, with a start/busy/done handshake.
module serializador_dac #(
  parameter int N       = 25,  // input sample width, two's complement
  parameter int FRAC    = 16,  // fractional bits of the input, >= 11
  parameter int CLK_DIV = 2    // clk cycles per sclk half-period, >= 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic signed [N-1:0] In,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                sat,
  output logic                sync_n,
  output logic                sclk,
  output logic                sdata
);

  localparam int SHIFT_AMT = FRAC - 11;
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic signed [N-1:0] CODE_MAX = N'(2047);
  localparam logic signed [N-1:0] CODE_MIN = N'(-2048);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t            r_state;
  logic [15:0]       r_shift;
  logic [DW-1:0]     r_div;
  logic [4:0]        r_falls;
  logic              r_busy;
  logic              r_done;
  logic              r_sat;
  logic              r_sync_n;
  logic              r_sclk;
  logic              r_sdata;

  logic signed [N-1:0] w_scaled;
  logic [11:0]         w_level;
  logic                w_clip;
  logic [15:0]         w_frame;

  // Scale to 12 integer-weighted bits, clip to the DAC range, build the frame.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_scaled = In >>> SHIFT_AMT;
    w_level  = w_scaled[11:0];
    w_clip   = 1'b0;
    if (w_scaled > CODE_MAX) begin
      w_level = 12'h7FF;
      w_clip  = 1'b1;
    end else if (w_scaled < CODE_MIN) begin
      w_level = 12'h800;
      w_clip  = 1'b1;
    end
    // Flipping the sign bit turns two's complement into offset binary.
    w_frame = {4'b0000, ~w_level[11], w_level[10:0]};
  end

  // Frame sequencer: IDLE -> SHIFT (32 sclk half-periods) -> GAP -> IDLE.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      // NOTE: the shift register is plain flops (not a RAM), so it is cleared
      // with the rest of the state and an aborted frame leaves no residue.
      r_shift  <= '0;
      r_div    <= '0;
      r_falls  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
      r_sync_n <= 1'b1;
      r_sclk   <= 1'b1;
      r_sdata  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift  <= w_frame;
            r_sdata  <= w_frame[15];
            r_sat    <= w_clip;
            r_div    <= '0;
            r_falls  <= '0;
            r_sclk   <= 1'b1;
            r_sync_n <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end

        SHIFT: begin
          if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              // Falling edge: the DAC samples sdata here.
              r_falls <= r_falls + 5'd1;
            end else if (r_falls == 5'd16) begin
              // sclk back high after the last bit: release the frame.
              r_sync_n <= 1'b1;
              r_sdata  <= 1'b0;
              r_state  <= GAP;
            end else begin
              // Rising edge: present the next bit for the coming falling edge.
              r_shift <= {r_shift[14:0], 1'b0};
              r_sdata <= r_shift[14];
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        GAP: begin
          if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign sat    = r_sat;
  assign sync_n = r_sync_n;
  assign sclk   = r_sclk;
  assign sdata  = r_sdata;

endmodule
